// File: rtl/shift_reg_pkg.sv
// Shared constants for the universal shift register: operation encoding,
// maximum supported width and a parity helper used by the optional
// PARITY_OUT_EN build.
package shift_reg_pkg;

    localparam int WIDTH_MAX = 32;

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    // Even-parity bit of a zero-extended register image.
    function automatic logic parity_of(input logic [WIDTH_MAX-1:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/shift_reg_univ_dff_en_cell.sv
// One-bit D flip-flop with synchronous active-high reset to a per-bit
// value and a clock enable. Provides true and complemented outputs.
module dff_en_cell #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic d,
    output logic q,
    output logic q_bar
);

    logic q_r;

    // Storage bit: reset has priority over enable; disabled cells hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_r <= RST_VAL;
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q     = q_r;
    assign q_bar = ~q_r;

endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: hold, parallel load, logical shifts,
// rotates, arithmetic shift right and synchronous clear, with serial
// outputs for chaining.
// Optional feature: define PARITY_OUT_EN to add a registered 'parity'
// output (XOR of q, updated on the same edge as q).
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sl_in,
    input  logic             sr_in,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             so_msb,
`ifdef PARITY_OUT_EN
    output logic             parity,
`endif
    output logic             so_lsb
);

    logic [WIDTH-1:0] q_s;
    logic [WIDTH-1:0] q_bar_s;
    logic [WIDTH-1:0] next_q_s;

    // Each bit picks its next value from its neighbours; the end bits pull
    // from the serial inputs or wrap around. With WIDTH=1 the wrap and
    // sign neighbours are the bit itself, so ROL/ROR/ASR hold.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        logic left_shl_s;
        logic left_rol_s;
        logic right_shr_s;
        logic right_ror_s;
        logic right_asr_s;
        logic nxt_s;

        if (i == 0) begin : g_lsb
            assign left_shl_s = sl_in;
            assign left_rol_s = q_s[WIDTH-1];
        end else begin : g_lsb_inner
            assign left_shl_s = q_s[i-1];
            assign left_rol_s = q_s[i-1];
        end

        if (i == WIDTH - 1) begin : g_msb
            assign right_shr_s = sr_in;
            assign right_ror_s = q_s[0];
            assign right_asr_s = q_s[WIDTH-1];
        end else begin : g_msb_inner
            assign right_shr_s = q_s[i+1];
            assign right_ror_s = q_s[i+1];
            assign right_asr_s = q_s[i+1];
        end

        // Per-bit next-state selection by operation mode.
        always_comb begin
            nxt_s = q_s[i];
            case (mode)
                MODE_HOLD: nxt_s = q_s[i];
                MODE_LOAD: nxt_s = d[i];
                MODE_SHL:  nxt_s = left_shl_s;
                MODE_SHR:  nxt_s = right_shr_s;
                MODE_ROL:  nxt_s = left_rol_s;
                MODE_ROR:  nxt_s = right_ror_s;
                MODE_ASR:  nxt_s = right_asr_s;
                MODE_CLR:  nxt_s = 1'b0;
                default:   nxt_s = q_s[i];
            endcase
        end

        assign next_q_s[i] = nxt_s;

        dff_en_cell #(
            .RST_VAL (RESET_VAL[i])
        ) u_cell (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .d     (nxt_s),
            .q     (q_s[i]),
            .q_bar (q_bar_s[i])
        );
    end

    assign q      = q_s;
    assign q_bar  = q_bar_s;
    assign so_msb = q_s[WIDTH-1];
    assign so_lsb = q_s[0];

`ifdef PARITY_OUT_EN
    logic                 parity_r;
    logic [WIDTH_MAX-1:0] next_ext_s;
    logic [WIDTH_MAX-1:0] rst_ext_s;

    // Zero-extend next state and reset value to the helper's fixed width.
    always_comb begin
        next_ext_s                = '0;
        next_ext_s[WIDTH-1:0]     = next_q_s;
        rst_ext_s                 = '0;
        rst_ext_s[WIDTH-1:0]      = RESET_VAL;
    end

    // Parity is taken from next-q so it changes on the same edge as q.
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_r <= parity_of(rst_ext_s);
        end else if (en) begin
            parity_r <= parity_of(next_ext_s);
        end else begin
            parity_r <= parity_r;
        end
    end

    assign parity = parity_r;
`endif

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: directed scenarios plus random
// stimulus against an arithmetic reference model, for WIDTH=8 and WIDTH=1.
module tb_shift_reg_univ;

    localparam logic [2:0] M_HOLD = 3'd0;
    localparam logic [2:0] M_LOAD = 3'd1;
    localparam logic [2:0] M_SHL  = 3'd2;
    localparam logic [2:0] M_SHR  = 3'd3;
    localparam logic [2:0] M_ROL  = 3'd4;
    localparam logic [2:0] M_ROR  = 3'd5;
    localparam logic [2:0] M_ASR  = 3'd6;
    localparam logic [2:0] M_CLR  = 3'd7;

    int checks   = 0;
    int failures = 0;

    logic       clk = 1'b0;
    logic       rst, en, sl_in, sr_in;
    logic [2:0] mode;
    logic [7:0] d;
    logic [7:0] q, q_bar;
    logic       so_msb, so_lsb;
    logic       parity;

    logic       rst1, en1, sl1, sr1;
    logic [2:0] mode1;
    logic [0:0] d1, q1, qb1;
    logic       msb1, lsb1;
    logic       parity1;

    logic [7:0] m8;
    logic       m1;

    always #5 clk = ~clk;

    shift_reg_univ #(.WIDTH(8), .RESET_VAL(8'hA5)) u_dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .d(d),
        .sl_in(sl_in), .sr_in(sr_in), .q(q), .q_bar(q_bar),
        .so_msb(so_msb),
`ifdef PARITY_OUT_EN
        .parity(parity),
`endif
        .so_lsb(so_lsb)
    );

    shift_reg_univ #(.WIDTH(1), .RESET_VAL(1'b0)) u_dut1 (
        .clk(clk), .rst(rst1), .en(en1), .mode(mode1), .d(d1),
        .sl_in(sl1), .sr_in(sr1), .q(q1), .q_bar(qb1),
        .so_msb(msb1),
`ifdef PARITY_OUT_EN
        .parity(parity1),
`endif
        .so_lsb(lsb1)
    );

`ifndef PARITY_OUT_EN
    assign parity  = 1'b0;
    assign parity1 = 1'b0;
`endif

    // Reference: next register value from the operation rules, using
    // integer arithmetic on a w-bit value.
    function automatic int unsigned model_next(input int unsigned cur, input int w,
            input logic r, input logic e, input logic [2:0] md, input int unsigned dv,
            input logic sl, input logic sr, input int unsigned rv);
        int unsigned mask, top;
        mask = (32'd1 << w) - 32'd1;
        top  = 32'd1 << (w - 1);
        if (r) return rv & mask;
        if (!e) return cur;
        case (md)
            M_LOAD: return dv & mask;
            M_SHL:  return ((cur * 2) + sl) & mask;
            M_SHR:  return (cur / 2) + (sr ? top : 0);
            M_ROL:  return ((cur * 2) + ((cur & top) != 0 ? 1 : 0)) & mask;
            M_ROR:  return (cur / 2) + ((cur % 2) != 0 ? top : 0);
            M_ASR:  return (cur / 2) | (cur & top);
            M_CLR:  return 0;
            default: return cur;
        endcase
    endfunction

    task automatic drive8(input logic r, input logic e, input logic [2:0] md,
                          input logic [7:0] dv, input logic sl, input logic sr);
        rst = r; en = e; mode = md; d = dv; sl_in = sl; sr_in = sr;
        @(posedge clk); #1;
        m8 = 8'(model_next(32'(m8), 8, r, e, md, 32'(dv), sl, sr, 32'hA5));
    endtask

    task automatic drive1(input logic r, input logic e, input logic [2:0] md,
                          input logic dv, input logic sl, input logic sr);
        rst1 = r; en1 = e; mode1 = md; d1 = dv; sl1 = sl; sr1 = sr;
        @(posedge clk); #1;
        m1 = 1'(model_next(32'(m1), 1, r, e, md, 32'(dv), sl, sr, 32'h0));
    endtask

    task automatic test_reset();
        m8 = 8'h00;
        drive8(1'b1, 1'b1, M_LOAD, 8'hFF, 1'b0, 1'b0);
        drive8(1'b1, 1'b1, M_LOAD, 8'hFF, 1'b0, 1'b0);
        checks++;
        if ({q, q_bar, so_msb, so_lsb} !== {8'hA5, 8'h5A, 1'b1, 1'b1}) begin
            failures++;
            $display("FAIL reset q=%h q_bar=%h msb=%b lsb=%b required A5 5A 1 1", q, q_bar, so_msb, so_lsb);
        end
`ifdef PARITY_OUT_EN
        checks++;
        if (parity !== 1'b0) begin
            failures++;
            $display("FAIL reset_parity got=%b required=0", parity);
        end
`endif
    endtask

    task automatic test_load_hold();
        drive8(1'b0, 1'b1, M_LOAD, 8'h3C, 1'b0, 1'b0);
        checks++;
        if (q !== 8'h3C) begin failures++; $display("FAIL load got=%h required=3c", q); end
        for (int i = 0; i < 3; i++) begin
            drive8(1'b0, 1'b0, M_SHL, 8'h00, 1'b1, 1'b1);
            checks++;
            if (q !== 8'h3C) begin failures++; $display("FAIL en0_hold[%0d] got=%h required=3c", i, q); end
        end
        drive8(1'b0, 1'b1, M_HOLD, 8'hFF, 1'b1, 1'b1);
        checks++;
        if (q !== 8'h3C) begin failures++; $display("FAIL mode_hold got=%h required=3c", q); end
    endtask

    task automatic test_shifts();
        drive8(1'b0, 1'b1, M_LOAD, 8'h81, 1'b0, 1'b0);
        drive8(1'b0, 1'b1, M_SHL, 8'h00, 1'b0, 1'b0);
        checks++;
        if (q !== 8'h02) begin failures++; $display("FAIL shl got=%h required=02", q); end
        drive8(1'b0, 1'b1, M_LOAD, 8'h81, 1'b0, 1'b0);
        drive8(1'b0, 1'b1, M_SHR, 8'h00, 1'b0, 1'b1);
        checks++;
        if (q !== 8'hC0) begin failures++; $display("FAIL shr got=%h required=c0", q); end
        drive8(1'b0, 1'b1, M_LOAD, 8'h81, 1'b0, 1'b0);
        drive8(1'b0, 1'b1, M_ASR, 8'h00, 1'b0, 1'b0);
        checks++;
        if (q !== 8'hC0) begin failures++; $display("FAIL asr_neg got=%h required=c0", q); end
        drive8(1'b0, 1'b1, M_LOAD, 8'h01, 1'b0, 1'b0);
        drive8(1'b0, 1'b1, M_ASR, 8'h00, 1'b1, 1'b1);
        checks++;
        if (q !== 8'h00) begin failures++; $display("FAIL asr_pos got=%h required=00", q); end
    endtask

    task automatic test_rotates();
        drive8(1'b0, 1'b1, M_LOAD, 8'h81, 1'b0, 1'b0);
        drive8(1'b0, 1'b1, M_ROL, 8'h00, 1'b0, 1'b0);
        checks++;
        if (q !== 8'h03) begin failures++; $display("FAIL rol got=%h required=03", q); end
        drive8(1'b0, 1'b1, M_LOAD, 8'h81, 1'b0, 1'b0);
        drive8(1'b0, 1'b1, M_ROR, 8'h00, 1'b0, 1'b0);
        checks++;
        if (q !== 8'hC0) begin failures++; $display("FAIL ror got=%h required=c0", q); end
        drive8(1'b0, 1'b1, M_LOAD, 8'h96, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive8(1'b0, 1'b1, M_ROL, 8'h00, 1'b0, 1'b0);
            checks++;
            if (q !== m8) begin failures++; $display("FAIL rol8_step[%0d] got=%h required=%h", i, q, m8); end
        end
        checks++;
        if (q !== 8'h96) begin failures++; $display("FAIL rol8_wrap got=%h required=96", q); end
    endtask

    task automatic test_clr_vs_rst();
        logic [7:0] exp_q [4]   = '{8'h77, 8'h00, 8'hA5, 8'h01};
        logic       exp_par [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: drive8(1'b0, 1'b1, M_LOAD, 8'h77, 1'b0, 1'b0);
                1: drive8(1'b0, 1'b1, M_CLR, 8'hFF, 1'b1, 1'b1);
                2: drive8(1'b1, 1'b1, M_SHL, 8'hFF, 1'b1, 1'b1);
                default: drive8(1'b0, 1'b1, M_LOAD, 8'h01, 1'b0, 1'b0);
            endcase
            checks++;
            if (q !== exp_q[i]) begin failures++; $display("FAIL clr_rst[%0d] got=%h required=%h", i, q, exp_q[i]); end
`ifdef PARITY_OUT_EN
            checks++;
            if (parity !== exp_par[i]) begin failures++; $display("FAIL clr_rst_parity[%0d] got=%b required=%b", i, parity, exp_par[i]); end
`else
            if (exp_par[i] === 1'bx) $display("unexpected");
`endif
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            drive8(($urandom_range(15) == 0), ($urandom_range(3) != 0), 3'($urandom_range(7)),
                   8'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if ({q, q_bar, so_msb, so_lsb} !== {m8, ~m8, m8[7], m8[0]}) begin
                failures++;
                $display("FAIL random[%0d] q=%h q_bar=%h msb=%b lsb=%b required q=%h", i, q, q_bar, so_msb, so_lsb, m8);
            end
`ifdef PARITY_OUT_EN
            checks++;
            if (parity !== ^m8) begin failures++; $display("FAIL random_parity[%0d] got=%b required=%b", i, parity, ^m8); end
`endif
        end
    endtask

    task automatic test_width1();
        m1 = 1'b1;
        drive1(1'b1, 1'b1, M_LOAD, 1'b1, 1'b1, 1'b1);
        checks++;
        if (q1 !== 1'b0) begin failures++; $display("FAIL w1_reset got=%b required=0", q1); end
        drive1(1'b0, 1'b1, M_SHL, 1'b0, 1'b1, 1'b0);
        checks++;
        if ({q1, qb1} !== 2'b10) begin failures++; $display("FAIL w1_shl q=%b q_bar=%b required 1 0", q1, qb1); end
        for (int k = 0; k < 3; k++) begin
            drive1(1'b0, 1'b1, 3'(M_ROL + k), 1'b0, 1'b0, 1'b0);
            checks++;
            if (q1 !== 1'b1) begin failures++; $display("FAIL w1_hold_mode%0d got=%b required=1", M_ROL + k, q1); end
        end
        drive1(1'b0, 1'b1, M_SHR, 1'b1, 1'b1, 1'b0);
        checks++;
        if (q1 !== 1'b0) begin failures++; $display("FAIL w1_shr got=%b required=0", q1); end
        for (int i = 0; i < 100; i++) begin
            drive1(($urandom_range(15) == 0), ($urandom_range(3) != 0), 3'($urandom_range(7)),
                   1'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if ({q1, qb1, msb1, lsb1} !== {m1, ~m1, m1, m1}) begin
                failures++;
                $display("FAIL w1_random[%0d] q=%b q_bar=%b msb=%b lsb=%b required q=%b", i, q1, qb1, msb1, lsb1, m1);
            end
`ifdef PARITY_OUT_EN
            checks++;
            if (parity1 !== m1) begin failures++; $display("FAIL w1_parity[%0d] got=%b required=%b", i, parity1, m1); end
`endif
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = M_HOLD; d = 8'h00; sl_in = 1'b0; sr_in = 1'b0;
        rst1 = 1'b1; en1 = 1'b0; mode1 = M_HOLD; d1 = 1'b0; sl1 = 1'b0; sr1 = 1'b0;
        m8 = 8'h00;
        m1 = 1'b0;
        test_reset();
        test_load_hold();
        test_shifts();
        test_rotates();
        test_clr_vs_rst();
        test_random();
        test_width1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
